// File: rtl/trace_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trace_capture: records the {d,en,q} probe triple for DEPTH edges, then replays it on a valid/ready stream
// Rev 1.0
// ----------------------------------------------------------------------------
module trace_capture #(
  parameter int DEPTH  = 17,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              d,
  input  logic              en,
  input  logic              q,
  output logic              capturing,
  output logic              full,
  output logic [ADDR_W-1:0] count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [2:0]        rd_data,
  output logic              rd_last
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DUMP    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_full;
  logic [2:0]        r_mem [0:DEPTH-1];

  logic w_wr_last;
  logic w_rd_at_last;
  logic w_xfer;

  assign w_wr_last    = (r_count == C_LAST);
  assign w_rd_at_last = (r_rd_ptr == C_LAST);
  assign w_xfer       = (r_state == S_DUMP) && rd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_wr_last) w_state_nxt = S_DUMP;
      S_DUMP:    if (w_xfer && w_rd_at_last) w_state_nxt = S_DONE;
      S_DONE:    if (start) w_state_nxt = S_CAPTURE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capturing = (r_state == S_CAPTURE);
    rd_valid  = (r_state == S_DUMP);
    rd_last   = (r_state == S_DUMP) && w_rd_at_last;
    rd_data   = (r_state == S_DUMP) ? r_mem[r_rd_ptr] : 3'b000;
    full      = r_full;
    count     = r_count;
  end

  // The write index doubles as the entry count; it reaches DEPTH only on the final capture edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_count <= '0;
            r_full  <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_count <= r_count + 1'b1;
          if (w_wr_last) begin
            r_full   <= 1'b1;
            r_rd_ptr <= '0;
          end
        end
        S_DUMP: begin
          if (w_xfer && !w_rd_at_last) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      r_mem[r_count] <= {d, en, q};
    end
  end

endmodule
`default_nettype wire
